register_file: RTL and testbench
================================

# register_file

32-entry × 32-bit integer register file for the RV32I pipeline: one synchronous write port and two asynchronous read ports. It sits in the decode stage. The write-back stage writes it through port D; the two read ports A and B supply rs1/rs2 operands. Register x0 is hard-wired to zero.

## Interface
- DATA_W, default 32: register width in bits.
- ADDR_W, default 5: address width; depth = 2**ADDR_W (32).
- clk  input  1  clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high reset; clears every register to 0.
- reg_write  input  1  write enable for port D, sampled on rising clk.
- addrA  input  ADDR_W  read address, port A.
- addrB  input  ADDR_W  read address, port B.
- addrD  input  ADDR_W  write address, port D.
- dataD  input  DATA_W  write data, port D.
- dataA  output  DATA_W  read data for addrA (combinational).
- dataB  output  DATA_W  read data for addrB (combinational).

## Operation
- Storage: registers x1..x31 are flops. x0 has no storage and always reads 0.
- Write: on a rising clk with reset low and reg_write=1 and addrD≠0, mem[addrD] ← dataD.
- Write to x0 (addrD=0) is silently discarded.
- When reg_write=0, storage holds its value.
- Reads: dataA = (addrA==0) ? 0 : mem[addrA]. dataB works the same way with addrB. Both are purely combinational, with no clock.
- Both ports may address the same register simultaneously; both return the same value.
- Reset: while reset=1, all of x1..x31 read 0 immediately, whatever the clock is doing. Writes are blocked while reset is asserted.
- No X propagation: outputs are defined from reset onward.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on a read port after edge N, following combinational settling.
- Read latency: 0 cycles, combinational from address to data.
- Same-cycle read of the address being written (no bypass): the port returns the old value until the edge, then the new value.
- Reset mid-operation: an asynchronous assert clears all registers at once. A write pending on the same edge as the reset assert is lost.
- Reset release is synchronous-safe: the first write takes effect on the first rising edge after reset drops.
- Reset values: dataA = dataB = 0 for every address.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled. If reg_write=1, addrD≠0 and addrX==addrD, then dataX = dataD combinationally in the same cycle. This lets write-back and decode share a cycle. Reads of x0 are still forced to 0, and bypass is suppressed while reset=1.
- REGFILE_BYPASS_EN undefined: reads return stored contents only, as described in Timing.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 32
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - ZERO_REG = 5'd0
  - typedef reg_addr_t (logic [4:0])
  - typedef xlen_t (logic [31:0])
- One sub-module, regfile_read_port, instantiated twice (A and B). It contains the 32:1 read mux, the x0 zero-forcing and the optional bypass compare.
- The top level holds the storage array and the write decode.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> dataA/dataB read 0 for addresses 5 and 10 with no clock edge needed.
- Write sweep: write 0x11111111+i to xi for i=1..31 (one per cycle), then read addrA=i, addrB=(i+1)%32 -> dataA = 0x11111111+i. dataB = 0x11111111+i+1, except for i=31 where it reads x0 = 0.
- Re-reset after fill: pulse reset -> x5 and x10 both read 0x00000000.
- x0 protection: write 0xDEADBEEF to addrD=0 with reg_write=1 -> dataA = dataB = 0 at addr 0 on following cycles.
- Write-disable: reg_write=0, addrD=7, dataD=0xCAFEBABE over several edges -> x7 keeps its prior value.
- Same-cycle read/write on x3 (old 0x1, new 0x2): without REGFILE_BYPASS_EN, dataA = 0x1 before the edge and 0x2 after. With REGFILE_BYPASS_EN, dataA = 0x2 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I constants and types used by the decode-stage register file.
//   XLEN       : integer register width (32)
//   REG_ADDR_W : register address width (5)
//   NUM_REGS   : architectural register count (32)
//   ZERO_REG   : index of the hard-wired zero register x0
//   reg_addr_t : register address type
//   xlen_t     : register data type
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [4:0]  ZERO_REG   = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file: full-depth read mux,
// optional write-to-read forwarding, and x0 zero-forcing.
// Ports:
//   regs     : input  - current register contents (entry 0 unused, reads 0)
//   addr     : input  - read address
//   byp_vld  : input  - forwarding candidate valid (tied low when disabled)
//   byp_addr : input  - address of the in-flight write
//   byp_data : input  - data of the in-flight write
//   data     : output - read data
// ---------------------------------------------------------------------------
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [ADDR_W-1:0] addr,
    input  logic              byp_vld,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = regs[addr];
        if (byp_vld && (addr == byp_addr)) begin
            data = byp_data;
        end
        // x0 wins over everything, including forwarding.
        if (addr == ADDR_W'(ZERO_REG)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32 x 32-bit RV32I integer register file: one synchronous write port (D),
// two combinational read ports (A, B). x0 has no storage and reads 0.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle forwarding of
// the port-D write to ports A/B (suppressed while reset is high).
// Ports:
//   clk       : input  - clock, writes on rising edge
//   reset     : input  - asynchronous active-high reset, clears x1..x31
//   reg_write : input  - port D write enable
//   addrA     : input  - port A read address
//   addrB     : input  - port B read address
//   addrD     : input  - port D write address
//   dataD     : input  - port D write data
//   dataA     : output - port A read data
//   dataB     : output - port B read data
// ---------------------------------------------------------------------------
module register_file
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [ADDR_W-1:0] addrD,
    input  logic [DATA_W-1:0] dataD,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    // Storage exists for x1..x(DEPTH-1) only.
    logic [DATA_W-1:0] mem  [1:DEPTH-1];
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic              byp_vld;

    assign wr_en = reg_write && (addrD != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addrD] <= dataD;
        end
    end

    always_comb begin
        regs[0] = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            regs[i] = mem[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp_vld = wr_en && !reset;
`else
    assign byp_vld = 1'b0;
`endif

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_port_a (
        .regs     (regs),
        .addr     (addrA),
        .byp_vld  (byp_vld),
        .byp_addr (addrD),
        .byp_data (dataD),
        .data     (dataA)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_port_b (
        .regs     (regs),
        .addr     (addrB),
        .byp_vld  (byp_vld),
        .byp_addr (addrD),
        .byp_data (dataD),
        .data     (dataB)
    );

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file. A plain array models the
// architectural registers; expected reads come from that model plus the
// x0 and forwarding rules.
// ---------------------------------------------------------------------------
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  addrA;
    logic [4:0]  addrB;
    logic [4:0]  addrD;
    logic [31:0] dataD;
    logic [31:0] dataA;
    logic [31:0] dataB;

    logic [31:0] model [32];
    int          n_cmp;
    int          n_err;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .addrA     (addrA),
        .addrB     (addrB),
        .addrD     (addrD),
        .dataD     (dataD),
        .dataA     (dataA),
        .dataB     (dataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!reset && reg_write && (addrD != 5'd0) && (a == addrD)) return dataD;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_A"}, dataA, exp_read(addrA));
        check({tag, "_B"}, dataB, exp_read(addrB));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Called just after a falling edge: apply, check pre-edge, clock, check post-edge.
    task automatic do_cycle(input string tag, input logic we, input logic [4:0] ad,
                            input logic [31:0] dd, input logic [4:0] aa, input logic [4:0] ab);
        reg_write = we;
        addrD     = ad;
        dataD     = dd;
        addrA     = aa;
        addrB     = ab;
        #1;
        check_ports({tag, "_pre"});
        @(posedge clk);
        if (!reset && we && ad != 5'd0) model[ad] = dd;
        #1;
        check_ports({tag, "_post"});
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        reg_write = 1'b0;
        addrA     = 5'd5;
        addrB     = 5'd10;
        addrD     = 5'd0;
        dataD     = 32'h0;
        clear_model();
        #1;
        check("reset_x5", dataA, 32'h0);
        check("reset_x10", dataB, 32'h0);
        @(negedge clk);

        // Writes while reset is held must be discarded (and not forwarded).
        do_cycle("wr_in_reset", 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd10);
        reset = 1'b0;

        // Write sweep, then readback with B one register ahead.
        for (int i = 1; i < 32; i++) begin
            do_cycle("sweep", 1'b1, 5'(i), 32'h11111111 + 32'(i), 5'(i), 5'(i + 1));
        end
        for (int i = 1; i < 32; i++) begin
            logic [31:0] exp_b;
            exp_b = (i == 31) ? 32'h0 : 32'h11111111 + 32'(i + 1);
            addrA     = 5'(i);
            addrB     = 5'(i + 1);
            reg_write = 1'b0;
            #1;
            check("fill_A", dataA, 32'h11111111 + 32'(i));
            check("fill_B", dataB, exp_b);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle, no clock edge needed.
        addrA = 5'd5;
        addrB = 5'd10;
        #3;
        reset = 1'b1;
        clear_model();
        #1;
        check("rereset_x5", dataA, 32'h0);
        check("rereset_x10", dataB, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // First write after reset release lands on the first rising edge.
        do_cycle("post_rst_wr", 1'b1, 5'd7, 32'h00000077, 5'd7, 5'd7);

        // x0 protection.
        do_cycle("x0_write", 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        do_cycle("x0_read", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("x0_const", dataA, 32'h0);

        // Write disable: x7 keeps 0x77.
        for (int k = 0; k < 3; k++) begin
            do_cycle("wr_dis", 1'b0, 5'd7, 32'hCAFEBABE, 5'd7, 5'd7);
        end
        check("wr_dis_x7", dataA, 32'h00000077);

        // Same-cycle read of the register being written.
        do_cycle("x3_old", 1'b1, 5'd3, 32'h1, 5'd3, 5'd4);
        reg_write = 1'b1;
        addrD     = 5'd3;
        dataD     = 32'h2;
        addrA     = 5'd3;
        addrB     = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x3_same_pre", dataA, 32'h2);
`else
        check("x3_same_pre", dataA, 32'h1);
`endif
        @(posedge clk);
        model[3] = 32'h2;
        #1;
        check("x3_same_post", dataA, 32'h2);
        check("x3_same_postB", dataB, 32'h2);
        @(negedge clk);

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            do_cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Reset asserted with a write pending on the same edge: write is lost.
        reg_write = 1'b1;
        addrD     = 5'd9;
        dataD     = 32'hA5A5A5A5;
        addrA     = 5'd9;
        addrB     = 5'd1;
        @(posedge clk);
        reset = 1'b1;
        clear_model();
        #1;
        check_ports("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        do_cycle("after_rst", 1'b0, 5'd9, 32'h0, 5'd9, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
